// File: rtl/draw_pkg.sv
// Shared definitions for the layer compositor: FSM encoding, default
// geometry/colour constants and the layer-index width helper.
package draw_pkg;

   localparam int          DEF_X_W       = 9;
   localparam int          DEF_Y_W       = 8;
   localparam int          DEF_COLOR_W   = 12;
   localparam logic [11:0] DEF_KEY_COLOR = 12'h000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_START,
      ST_WAIT,
      ST_DONE
   } state_t;

   // Width of an index that can address n layers (at least 1 bit).
   function automatic int layer_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/layer_pixel_mux.sv
// Registered N:1 pixel mux. Forwards the selected layer's pixel with one
// cycle of latency and suppresses writes of key-coloured pixels on layers
// that honour transparency. Layer 0 is always opaque.
module layer_pixel_mux
   import draw_pkg::*;
#(
   parameter int                      NUM_LAYERS  = 6,
   parameter int                      X_W         = DEF_X_W,
   parameter int                      Y_W         = DEF_Y_W,
   parameter int                      COLOR_W     = DEF_COLOR_W,
   parameter logic [COLOR_W-1:0]      KEY_COLOR   = COLOR_W'(DEF_KEY_COLOR),
   parameter logic [NUM_LAYERS-1:0]   TRANSP_MASK = NUM_LAYERS'(6'b111110),
   parameter int                      SEL_W       = layer_idx_w(NUM_LAYERS)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  active,
   input  logic [SEL_W-1:0]                      sel,
   input  logic [NUM_LAYERS-1:0][X_W-1:0]        layer_x,
   input  logic [NUM_LAYERS-1:0][Y_W-1:0]        layer_y,
   input  logic [NUM_LAYERS-1:0][COLOR_W-1:0]    layer_color,
   input  logic [NUM_LAYERS-1:0]                 layer_we,
   output logic [X_W-1:0]                        X_out,
   output logic [Y_W-1:0]                        Y_out,
   output logic [COLOR_W-1:0]                    Color_out,
   output logic                                  writeEn
);

   // Background layer can never be keyed out, whatever the mask says.
   localparam logic [NUM_LAYERS-1:0] MASK_EFF = TRANSP_MASK & ~NUM_LAYERS'(1);

   logic keyed;

   // Key test looks at the incoming colour so the gate lines up with the pixel.
   always_comb begin
      keyed = MASK_EFF[sel] & (layer_color[sel] == KEY_COLOR);
   end

   // Pixel register: loads only while a layer is being forwarded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         X_out     <= '0;
         Y_out     <= '0;
         Color_out <= '0;
         writeEn   <= 1'b0;
      end else begin
         writeEn <= active & layer_we[sel] & ~keyed;
         if (active) begin
            X_out     <= layer_x[sel];
            Y_out     <= layer_y[sel];
            Color_out <= layer_color[sel];
         end
      end
   end

endmodule

// File: rtl/draw_layer_sequencer.sv
// Back-to-front layer compositor. Walks the enabled layers in index order,
// hands each one a start pulse, forwards its pixels until it reports done
// (or its watchdog expires), then signals end of frame.
module draw_layer_sequencer
   import draw_pkg::*;
#(
   parameter int                      NUM_LAYERS  = 6,
   parameter int                      X_W         = DEF_X_W,
   parameter int                      Y_W         = DEF_Y_W,
   parameter int                      COLOR_W     = DEF_COLOR_W,
   parameter logic [COLOR_W-1:0]      KEY_COLOR   = COLOR_W'(DEF_KEY_COLOR),
   parameter logic [NUM_LAYERS-1:0]   TRANSP_MASK = NUM_LAYERS'(6'b111110),
   parameter int                      TIMEOUT_CYC = 0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              frame_go,
   input  logic [NUM_LAYERS-1:0]             layer_en,
   input  logic [NUM_LAYERS*X_W-1:0]         layer_x,
   input  logic [NUM_LAYERS*Y_W-1:0]         layer_y,
   input  logic [NUM_LAYERS*COLOR_W-1:0]     layer_color,
   input  logic [NUM_LAYERS-1:0]             layer_we,
   input  logic [NUM_LAYERS-1:0]             layer_done,
   output logic [NUM_LAYERS-1:0]             layer_start,
   output logic [X_W-1:0]                    X_out,
   output logic [Y_W-1:0]                    Y_out,
   output logic [COLOR_W-1:0]                Color_out,
   output logic                              writeEn,
   output logic                              busy,
   output logic                              frame_done,
   output logic [$clog2(NUM_LAYERS)-1:0]     cur_layer,
   output logic [NUM_LAYERS-1:0]             layer_timeout
);

   localparam int IW = layer_idx_w(NUM_LAYERS);

   state_t                  state_q, state_d;
   logic [NUM_LAYERS-1:0]   mask_q;
   logic [IW:0]             idx_q;      // extra bit: may reach NUM_LAYERS, never wraps
   logic [31:0]             wdog_q;
   logic                    found;
   logic [IW-1:0]           found_idx;
   logic                    done_hit;
   logic                    wdog_hit;

   logic [NUM_LAYERS-1:0][X_W-1:0]     lx;
   logic [NUM_LAYERS-1:0][Y_W-1:0]     ly;
   logic [NUM_LAYERS-1:0][COLOR_W-1:0] lc;

   assign lx = layer_x;
   assign ly = layer_y;
   assign lc = layer_color;

   // Lowest enabled layer at or above idx; descending scan so the lowest wins.
   always_comb begin
      found     = 1'b0;
      found_idx = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (mask_q[i] && ((IW+1)'(i) >= idx_q)) begin
            found     = 1'b1;
            found_idx = IW'(i);
         end
      end
   end

   // Only the active layer's done counts; watchdog fires on its last allowed cycle.
   always_comb begin
      done_hit = layer_done[cur_layer];
      wdog_hit = (TIMEOUT_CYC != 0) && (wdog_q == 32'(TIMEOUT_CYC - 1));
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_d     = state_q;
      busy        = 1'b0;
      frame_done  = 1'b0;
      layer_start = '0;
      case (state_q)
         ST_IDLE:  if (frame_go) state_d = ST_SEL;
         ST_SEL: begin
            busy    = 1'b1;
            state_d = found ? ST_START : ST_DONE;
         end
         ST_START: begin
            busy        = 1'b1;
            layer_start = NUM_LAYERS'(1) << cur_layer;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            busy = 1'b1;
            if (done_hit || wdog_hit) state_d = ST_SEL;
         end
         ST_DONE: begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Frame bookkeeping: latched mask, search index, active layer, watchdog, flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q        <= '0;
         idx_q         <= '0;
         cur_layer     <= '0;
         wdog_q        <= '0;
         layer_timeout <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (frame_go) begin
               mask_q        <= layer_en;
               idx_q         <= '0;
               layer_timeout <= '0;
            end
            ST_SEL:   if (found) cur_layer <= found_idx;
            ST_START: wdog_q <= '0;
            ST_WAIT: begin
               wdog_q <= wdog_q + 32'd1;
               if (done_hit || wdog_hit) begin
                  idx_q <= {1'b0, cur_layer} + (IW+1)'(1);
                  if (!done_hit) layer_timeout[cur_layer] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   layer_pixel_mux #(
      .NUM_LAYERS  (NUM_LAYERS),
      .X_W         (X_W),
      .Y_W         (Y_W),
      .COLOR_W     (COLOR_W),
      .KEY_COLOR   (KEY_COLOR),
      .TRANSP_MASK (TRANSP_MASK),
      .SEL_W       (IW)
   ) u_mux (
      .clk         (clk),
      .reset       (reset),
      .active      (state_q == ST_WAIT),
      .sel         (cur_layer),
      .layer_x     (lx),
      .layer_y     (ly),
      .layer_color (lc),
      .layer_we    (layer_we),
      .X_out       (X_out),
      .Y_out       (Y_out),
      .Color_out   (Color_out),
      .writeEn     (writeEn)
   );

endmodule
